// File: rtl/cnn_layer_accel_result_packer.sv
// cnn_layer_accel_result_packer
// Collects 16-bit results from the quad, packs eight of them into each
// 128-bit word and queues the words in a small show-ahead FIFO for the
// writeback path. A job is sized by job_num_results; a short final word is
// flushed with its keep mask trimmed, and job_done marks the end of the job.
module cnn_layer_accel_result_packer #(
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                   clk_if,
    input  logic                   rst,
    input  logic                   job_start,
    input  logic [C_CNT_WIDTH-1:0] job_num_results,
    input  logic                   result_valid,
    output logic                   result_accept,
    input  logic [15:0]            result_data,
    output logic                   pack_valid,
    input  logic                   pack_ready,
    output logic [127:0]           pack_data,
    output logic [7:0]             pack_keep,
    output logic                   pack_last,
    output logic                   busy,
    output logic                   job_done
);

    localparam int PTR_W = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]         FIFO_FULL_LEVEL = (PTR_W+1)'(C_FIFO_DEPTH);
    localparam logic [PTR_W:0]         OCC_ONE         = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]       PTR_ONE         = PTR_W'(1);
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE         = C_CNT_WIDTH'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Job control and staging
    logic [1:0]             state;
    logic [C_CNT_WIDTH-1:0] n_reg;
    logic [C_CNT_WIDTH-1:0] count;
    logic [2:0]             lane_idx;
    logic [127:0]           stage_data;
    logic [7:0]             stage_keep;

    // Staging word with the incoming result merged in
    logic [127:0]           word_data;
    logic [7:0]             word_keep;
    logic                   transfer;
    logic                   final_result;
    logic                   commit;
    logic                   last_commit;

    // Output FIFO
    logic [127:0]           mem_data [C_FIFO_DEPTH];
    logic [7:0]             mem_keep [C_FIFO_DEPTH];
    logic                   mem_last [C_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         occ;
    logic [PTR_W:0]         occ_next;
    logic                   full_reg;
    logic                   push;
    logic                   pop;
    logic                   head_last;

    assign result_accept = (state == S_PACK) && !full_reg;
    assign transfer      = result_valid && result_accept;
    assign final_result  = (count + CNT_ONE) == n_reg;
    assign commit        = transfer && ((lane_idx == 3'd7) || final_result);
    assign last_commit   = transfer && final_result;
    assign push          = commit;

    assign pack_valid    = (occ != '0);
    assign pop           = pack_valid && pack_ready;
    assign head_last     = mem_last[rd_ptr];
    assign pack_data     = pack_valid ? mem_data[rd_ptr] : '0;
    assign pack_keep     = pack_valid ? mem_keep[rd_ptr] : '0;
    assign pack_last     = pack_valid && head_last;

    assign busy          = (state != S_IDLE);
    assign job_done      = (state == S_DONE);

    // Merge the incoming result into its lane of the staging word
    always_comb begin
        word_data = stage_data;
        word_data[{lane_idx, 4'b0000} +: 16] = result_data;
        word_keep = stage_keep | (8'b1 << lane_idx);
    end

    // Job sequencing, result counting and lane staging
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            n_reg      <= '0;
            count      <= '0;
            lane_idx   <= 3'd0;
            stage_data <= '0;
            stage_keep <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_start) begin
                        n_reg      <= job_num_results;
                        count      <= '0;
                        lane_idx   <= 3'd0;
                        stage_data <= '0;
                        stage_keep <= '0;
                        state      <= (job_num_results == '0) ? S_DONE : S_PACK;
                    end
                end
                S_PACK: begin
                    if (transfer) begin
                        count <= count + CNT_ONE;
                        if (commit) begin
                            stage_data <= '0;
                            stage_keep <= '0;
                            lane_idx   <= 3'd0;
                            if (last_commit) begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            stage_data <= word_data;
                            stage_keep <= word_keep;
                            lane_idx   <= lane_idx + 3'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && head_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by occupancy
    always_ff @(posedge clk_if) begin
        if (push) begin
            mem_data[wr_ptr] <= word_data;
            mem_keep[wr_ptr] <= word_keep;
            mem_last[wr_ptr] <= last_commit;
        end
    end

    // Next occupancy; accept is gated by full so push never meets a full FIFO
    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + OCC_ONE;
        end else if (pop && !push) begin
            occ_next = occ - OCC_ONE;
        end
    end

    // FIFO pointers, occupancy and the registered full flag
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            full_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            occ      <= occ_next;
            full_reg <= (occ_next == FIFO_FULL_LEVEL);
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// tb_cnn_layer_accel_result_packer
// Drives jobs into the result packer and compares every popped word, the
// job_done pulse and the busy window against words built from the job's
// result list.
module tb_cnn_layer_accel_result_packer;

    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic           clk_if = 1'b0;
    logic           rst;
    logic           job_start;
    logic [CW-1:0]  job_num_results;
    logic           result_valid;
    logic           result_accept;
    logic [15:0]    result_data;
    logic           pack_valid;
    logic           pack_ready;
    logic [127:0]   pack_data;
    logic [7:0]     pack_keep;
    logic           pack_last;
    logic           busy;
    logic           job_done;

    int checks = 0;
    int errors = 0;

    cnn_layer_accel_result_packer #(
        .C_FIFO_DEPTH(DEPTH),
        .C_CNT_WIDTH (CW)
    ) dut (
        .clk_if         (clk_if),
        .rst            (rst),
        .job_start      (job_start),
        .job_num_results(job_num_results),
        .result_valid   (result_valid),
        .result_accept  (result_accept),
        .result_data    (result_data),
        .pack_valid     (pack_valid),
        .pack_ready     (pack_ready),
        .pack_data      (pack_data),
        .pack_keep      (pack_keep),
        .pack_last      (pack_last),
        .busy           (busy),
        .job_done       (job_done)
    );

    // Free-running interface clock
    always #5 clk_if = ~clk_if;

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output($sformatf("%s ctrl", tag),
                     {result_accept, pack_valid, pack_keep, pack_last, busy, job_done}, '0);
        check_output($sformatf("%s data", tag), pack_data, '0);
    endtask

    // ready_mode: 0 = always ready, 1 = held low until cycle 'hold', 2 = random
    task automatic apply_stimulus(input string name, input int n, input bit rand_data,
                                  input logic [15:0] base, input int ready_mode,
                                  input int hold, input int restart_at, input int abort_at);
        logic [15:0]  vals[$];
        logic [127:0] exp_data[$];
        logic [7:0]   exp_keep[$];
        logic         exp_last[$];
        logic [127:0] obs_data[$];
        logic [7:0]   obs_keep[$];
        logic         obs_last[$];
        logic [127:0] d;
        logic [7:0]   k;
        int sent, stalls, done_count, done_at, last_pop, busy_cycles, tail, cyc, nw;
        bit timed_out;
        sent = 0; stalls = 0; done_count = 0; done_at = -1; last_pop = -1;
        busy_cycles = 0; tail = 0; cyc = 0; timed_out = 1'b0;

        for (int i = 0; i < n; i++) begin
            vals.push_back(rand_data ? 16'($urandom) : base + 16'(i));
        end
        nw = (n + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < 8; l++) begin
                if (w * 8 + l < n) begin
                    d[16*l +: 16] = vals[w*8+l];
                    k[l] = 1'b1;
                end
            end
            exp_data.push_back(d);
            exp_keep.push_back(k);
            exp_last.push_back(w == nw - 1);
        end

        @(posedge clk_if); #1;
        job_start       = 1'b1;
        job_num_results = CW'(n);
        result_valid    = 1'b0;
        pack_ready      = 1'b0;
        @(posedge clk_if); #1;
        job_start = 1'b0;

        while (1) begin
            job_start       = (cyc == restart_at);
            job_num_results = (cyc == restart_at) ? CW'(100) : CW'(n);
            result_valid    = (sent < n) && (ready_mode != 2 || $urandom_range(0, 3) != 0);
            result_data     = 16'h0;
            if (sent < n) result_data = vals[sent];
            case (ready_mode)
                0:       pack_ready = 1'b1;
                1:       pack_ready = (cyc > hold);
                default: pack_ready = 1'($urandom_range(0, 1));
            endcase

            @(negedge clk_if);
            if (ready_mode == 1 && cyc == hold) begin
                check_output($sformatf("%s accepted before full", name), sent, DEPTH * 8);
                check_output($sformatf("%s accept low when full", name), result_accept, 0);
            end
            if (result_valid) begin
                if (result_accept) sent++;
                else stalls++;
            end
            if (pack_valid && pack_ready) begin
                obs_data.push_back(pack_data);
                obs_keep.push_back(pack_keep);
                obs_last.push_back(pack_last);
                if (pack_last) last_pop = cyc;
            end
            if (job_done) begin
                done_count++;
                done_at = cyc;
            end
            if (busy) busy_cycles++;
            if (abort_at >= 0 && sent == abort_at) return;
            if (done_count > 0) tail++;
            if (tail >= 3) break;
            if (cyc >= 3000) begin
                timed_out = 1'b1;
                break;
            end
            cyc++;
            @(posedge clk_if); #1;
        end
        job_start    = 1'b0;
        result_valid = 1'b0;
        pack_ready   = 1'b0;

        check_output($sformatf("%s timeout", name), timed_out, 0);
        check_output($sformatf("%s word count", name), obs_data.size(), nw);
        for (int w = 0; w < nw; w++) begin
            if (w < obs_data.size()) begin
                check_output($sformatf("%s word%0d data", name, w), obs_data[w], exp_data[w]);
                check_output($sformatf("%s word%0d keep", name, w), obs_keep[w], exp_keep[w]);
                check_output($sformatf("%s word%0d last", name, w), obs_last[w], exp_last[w]);
            end
        end
        check_output($sformatf("%s done pulses", name), done_count, 1);
        if (n > 0) begin
            check_output($sformatf("%s done timing", name), done_at, last_pop + 1);
        end
        check_output($sformatf("%s busy span", name), busy_cycles, done_at + 1);
        if (ready_mode == 0) begin
            check_output($sformatf("%s accept stalls", name), stalls, 0);
        end
        check_output($sformatf("%s idle after", name), {busy, job_done, pack_valid}, 0);
    endtask

    // Directed job sequence followed by randomized jobs
    initial begin
        rst             = 1'b1;
        job_start       = 1'b0;
        job_num_results = '0;
        result_valid    = 1'b0;
        result_data     = 16'h0;
        pack_ready      = 1'b0;
        repeat (2) @(posedge clk_if);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        apply_stimulus("seq16",    16, 1'b0, 16'h0001, 0, 0,  -1, -1);
        apply_stimulus("seq11",    11, 1'b0, 16'hA000, 0, 0,  -1, -1);
        apply_stimulus("stall64",  64, 1'b1, 16'h0000, 1, 45, -1, -1);
        apply_stimulus("zero",      0, 1'b0, 16'h0000, 0, 0,  -1, -1);
        apply_stimulus("restart",   8, 1'b1, 16'h0000, 0, 0,   3, -1);
        apply_stimulus("after",    20, 1'b1, 16'h0000, 2, 0,  -1, -1);

        apply_stimulus("abort",    16, 1'b0, 16'h5000, 0, 0,  -1, 5);
        @(posedge clk_if); #3;
        result_valid = 1'b0;
        pack_ready   = 1'b0;
        rst          = 1'b1;
        #1;
        check_all_zero("async reset");
        @(posedge clk_if); #1;
        rst = 1'b0;
        check_output("post reset fifo empty", pack_valid, 0);
        apply_stimulus("post_rst",  8, 1'b1, 16'h0000, 0, 0,  -1, -1);
        apply_stimulus("short3",    3, 1'b1, 16'h0000, 0, 0,  -1, -1);

        for (int j = 0; j < 3; j++) begin
            apply_stimulus($sformatf("rand%0d", j), $urandom_range(1, 40), 1'b1, 16'h0000,
                           2, 0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_result_packer.md
Name: cnn_layer_accel_result_packer

Overview:
Downstream stage of cnn_layer_accel_quad. Consumes the quad's 16-bit result stream over the result_valid/result_accept handshake. Packs eight results into each 128-bit word and buffers the words in a small FIFO toward the output DMA/writeback path. Counts results against a per-job expected total, flushes a partial final word and reports job completion.

Parameters:
C_FIFO_DEPTH, 4, depth of the packed-word output FIFO in 128-bit entries (power of 2, >=2)
C_CNT_WIDTH, 32, width of the result counter and of job_num_results

Ports:
clk_if  in  1  interface clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
job_start  in  1  single-cycle pulse; loads job_num_results and starts a job (ignored unless IDLE)
job_num_results  in  C_CNT_WIDTH  expected result count (rows*cols*kernels), sampled on job_start
result_valid  in  1  quad result valid
result_accept  out  1  packer accepts a result this cycle
result_data  in  16  quad result value
pack_valid  out  1  FIFO head word valid
pack_ready  in  1  downstream accepts head word
pack_data  out  128  packed word; result k of the word in bits [16k+15:16k], k=0 first received
pack_keep  out  8  per-lane valid mask of head word
pack_last  out  1  head word is the final word of the job
busy  out  1  high from accepted job_start until job_done
job_done  out  1  single-cycle pulse when the last word of the job is popped

Behaviour:
- Reset (async, rst=1): state IDLE, counters/lane index/FIFO pointers cleared, staging register zeroed. Outputs result_accept=0, pack_valid=0, pack_data=0, pack_keep=0, pack_last=0, busy=0, job_done=0.
- States: IDLE, PACK, DRAIN, DONE.
- IDLE: on job_start, latch N=job_num_results and clear count and lane index.
  - N==0: go to DONE, produce no words.
  - Otherwise: go to PACK.
- PACK: result_accept = 1 when FIFO not full (registered full flag; no combinational path from pack_ready).
  - Transfer = result_valid & result_accept. On a transfer, write result_data into staging lane[lane_idx], set keep bit, increment count.
  - Word commit: push staging to FIFO when lane_idx==7 or count+1==N. The committed word carries keep=lanes written and last=(count+1==N).
  - After a commit: clear staging and keep, lane_idx=0. Unwritten lanes read 0.
  - After committing the last word: go to DRAIN, result_accept=0.
- DRAIN: wait until FIFO empty, i.e. the last word has been popped.
  - job_done pulses for one cycle in the cycle after the pop of the pack_last word.
  - Then go to DONE.
- DONE: lasts one cycle, then IDLE. For N==0, job_done pulses during DONE. busy deasserts together with job_done.
- Latency: a committed word appears on pack_valid the cycle after the commit transfer. Pop occurs on pack_valid & pack_ready.
- FIFO: show-ahead; pack_* reflect the head entry. Simultaneous push and pop when full is impossible, because accept is gated by full. Push and pop in the same cycle at any other occupancy keeps the count unchanged.
- Results presented while not in PACK: never accepted; result_accept=0.
- job_start while busy: ignored; the latched N is unchanged.
- Counter: N up to 2^C_CNT_WIDTH-1; no wrap within a job. lane_idx is 3 bits and wraps 7->0 only on commit.
- Full throughput: one result per cycle sustained while pack_ready stays high.

Test Plan:
- N=16, results 0x0001..0x0010 back-to-back, pack_ready=1 -> 2 words: word0 lanes 0x0001..0x0008, keep=0xFF, last=0; word1 lanes 0x0009..0x0010, keep=0xFF, last=1; job_done 1 cycle after word1 pop; no accept stalls.
- N=11, results 0xA000+i -> word1 keep=0x07, last=1, lanes 3..7 = 0; busy falls with job_done.
- N=64 with pack_ready held low -> result_accept drops after C_FIFO_DEPTH*8=32 results. Releasing pack_ready resumes accept; all 8 words arrive in order with no loss or duplication.
- N=0 job_start -> no pack_valid; job_done pulses exactly once within 2 cycles; busy high for 1-2 cycles.
- Second job_start mid-job (N=8 then N=100) -> ignored; the first job completes with exactly 1 word. A following job_start after IDLE is accepted.
- rst asserted asynchronously mid-PACK after 5 results -> all outputs 0 immediately, FIFO empty. A new N=8 job after reset produces one correct word with no stale lanes.
